// File: rtl/nrzi_decoder.sv
// NRZI receive decoder: samples the line on en, removes stuffed zeros after
// STUFF_LEN consecutive ones and assembles LSB-first bytes with a valid pulse.
module nrzi_decoder #(
  parameter int unsigned STUFF_LEN  = 6,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clear,
  input  logic       line,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       stuff_err
);

  localparam logic [3:0] STUFF_CNT = 4'(STUFF_LEN);

  logic       prev,    prev_n;
  logic [7:0] shreg,   shreg_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [3:0] ones_cnt, ones_cnt_n;
  logic [7:0] data_n;
  logic       valid_n, err_n;
  logic       raw, stuff_pos;

  always_comb begin
    raw        = ~(line ^ prev);
    stuff_pos  = (ones_cnt == STUFF_CNT);
    prev_n     = prev;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    ones_cnt_n = ones_cnt;
    data_n     = data;
    valid_n    = 1'b0;
    err_n      = 1'b0;

    // clear outranks en: the sample taken in a clear cycle is discarded
    if (clear) begin
      prev_n     = IDLE_LEVEL;
      shreg_n    = '0;
      bit_cnt_n  = '0;
      ones_cnt_n = '0;
    end else if (en) begin
      prev_n = line;
      if (stuff_pos) begin
        ones_cnt_n = '0;
        if (raw) begin
          err_n     = 1'b1;
          bit_cnt_n = '0;
          shreg_n   = '0;
        end
      end else begin
        shreg_n    = {raw, shreg[7:1]};
        bit_cnt_n  = bit_cnt + 3'd1;
        ones_cnt_n = raw ? ones_cnt + 4'd1 : '0;
        if (bit_cnt == 3'd7) begin
          data_n  = {raw, shreg[7:1]};
          valid_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev       <= IDLE_LEVEL;
      shreg      <= '0;
      bit_cnt    <= '0;
      ones_cnt   <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      stuff_err  <= 1'b0;
    end else begin
      prev       <= prev_n;
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      ones_cnt   <= ones_cnt_n;
      data       <= data_n;
      data_valid <= valid_n;
      stuff_err  <= err_n;
    end
  end

endmodule

// File: tb/tb_nrzi_decoder.sv
// Directed bench for nrzi_decoder (STUFF_LEN=6, IDLE_LEVEL=1).
module tb_nrzi_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clear = 1'b0;
  logic       line = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       stuff_err;

  int checks = 0;
  int errors = 0;
  logic cur = 1'b1;
  int samples = 0;
  int overlap = 0;
  logic [7:0] vq[$];
  int vat[$];
  int eat[$];

  nrzi_decoder #(.STUFF_LEN(6), .IDLE_LEVEL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .line(line),
    .data(data), .data_valid(data_valid), .stuff_err(stuff_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) samples <= 0;
    else if (en && !clear) samples <= samples + 1;

  always @(negedge clk) begin
    if (data_valid) begin vq.push_back(data); vat.push_back(samples); end
    if (stuff_err) eat.push_back(samples);
    if (data_valid && stuff_err) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    en   = 1'b1;
    line = b ? cur : ~cur;
    cur  = line;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic stop_en();
    @(negedge clk);
    en   = 1'b0;
    line = cur;
  endtask

  task automatic flush();
    repeat (3) @(negedge clk);
    vq.delete(); vat.delete(); eat.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0; clear = 1'b0; rst_n = 1'b0;
    cur = 1'b1; line = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    flush();
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_data", data, 8'h00);
    check("rst_valid", data_valid, 0);
    check("rst_err", stuff_err, 0);
    rst_n = 1'b1;
    flush();

    // plain 0xA5 from idle
    send_byte(8'hA5);
    stop_en();
    check("a5_valid_now", data_valid, 1);
    check("a5_data", data, 8'hA5);
    check("a5_err", stuff_err, 0);
    @(negedge clk);
    check("a5_valid_drop", data_valid, 0);
    check("a5_count", vq.size(), 1);
    flush();

    // reset mid-byte, then 0x3C
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    @(negedge clk);
    en = 1'b0; rst_n = 1'b0;
    #1;
    check("midrst_data", data, 8'h00);
    check("midrst_valid", data_valid, 0);
    cur = 1'b1; line = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    flush();
    send_byte(8'h3C);
    stop_en();
    repeat (2) @(negedge clk);
    check("3c_count", vq.size(), 1);
    check("3c_data", vq.size() > 0 ? vq[0] : 8'hEE, 8'h3C);
    check("3c_data_hold", data, 8'h3C);
    flush();

    // 0xFF then 0x00 with stuffed zero after six ones
    do_reset();
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b1);
    for (int i = 0; i < 8; i++) send_bit(1'b0);
    stop_en();
    @(negedge clk);
    check("ff00_count", vq.size(), 2);
    check("ff_data", vq.size() > 0 ? vq[0] : 8'hEE, 8'hFF);
    check("ff_at", vat.size() > 0 ? vat[0] : -1, 9);
    check("00_data", vq.size() > 1 ? vq[1] : 8'hEE, 8'h00);
    check("00_at", vat.size() > 1 ? vat[1] : -1, 17);
    check("ff00_err", eat.size(), 0);

    // stuffed zero directly after the 8th bit of 0xFC, then 0x00
    do_reset();
    send_byte(8'hFC);
    send_bit(1'b0);
    send_byte(8'h00);
    stop_en();
    @(negedge clk);
    check("fc_count", vq.size(), 2);
    check("fc_data", vq.size() > 0 ? vq[0] : 8'hEE, 8'hFC);
    check("fc_at", vat.size() > 0 ? vat[0] : -1, 8);
    check("fc_next", vq.size() > 1 ? vq[1] : 8'hEE, 8'h00);
    check("fc_next_at", vat.size() > 1 ? vat[1] : -1, 17);

    // stuff error on seventh one, then 0x81
    do_reset();
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    stop_en();
    check("serr_pulse", stuff_err, 1);
    check("serr_novalid", data_valid, 0);
    @(negedge clk);
    check("serr_drop", stuff_err, 0);
    check("serr_at", eat.size() > 0 ? eat[0] : -1, 7);
    check("serr_count", eat.size(), 1);
    check("serr_vcount", vq.size(), 0);
    send_byte(8'h81);
    stop_en();
    @(negedge clk);
    check("81_count", vq.size(), 1);
    check("81_data", vq.size() > 0 ? vq[0] : 8'hEE, 8'h81);

    // sparse strobe with line noise while en is low
    do_reset();
    begin
      logic [7:0] v;
      v = 8'hA5;
      for (int i = 0; i < 8; i++) begin
        int gap;
        gap = $urandom_range(0, 5);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          en = 1'b0;
          line = 1'($urandom);
        end
        send_bit(v[i]);
      end
    end
    stop_en();
    @(negedge clk);
    check("sparse_count", vq.size(), 1);
    check("sparse_data", vq.size() > 0 ? vq[0] : 8'hEE, 8'hA5);

    // clear mid-byte with en high; the clear-cycle sample must be ignored
    do_reset();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    @(negedge clk);
    en = 1'b1; clear = 1'b1; line = ~cur;
    @(negedge clk);
    clear = 1'b0; en = 1'b0;
    cur = 1'b1; line = 1'b1;
    check("clr_data_kept", data, 8'h00);
    send_byte(8'h5A);
    stop_en();
    @(negedge clk);
    check("clr_count", vq.size(), 1);
    check("clr_data", vq.size() > 0 ? vq[0] : 8'hEE, 8'h5A);
    check("clr_err", eat.size(), 0);

    check("no_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
